pwm_gate_drive: RTL and testbench
=================================

# pwm_gate_drive

Gate-drive stage for the constant-on-time PWM path. It consumes the converter's `set` request and the one-cycle `reset_pwm` end-of-on-time pulse, and holds the PWM state as a synchronous SR latch. It produces complementary high-side and low-side gate signals with dead-time insertion, minimum off-time lockout, maximum on-time protection and a latched fault shutdown. It sits directly downstream of the on-time counter and drives the gate-driver pins.

## Interface
- `DEAD_TIME`, 8: cycles with both gates low on every transition; must be ≥1.
- `MIN_OFF`, 20: cycles the block must spend in IDLE before a new `set` edge is accepted.
- `MAX_ON`, 2000: on-time limit in cycles; forces turn-off if `reset_pwm` never arrives.
- `CNT_W`, 21: counter width; must hold max(`DEAD_TIME`, `MIN_OFF`, `MAX_ON`).

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `set`, in, 1: on request; acted on at its rising edge.
- `reset_pwm`, in, 1: one-cycle end-of-on-time pulse.
- `fault`, in, 1: level overcurrent/UVLO fault.
- `clr_fault`, in, 1: fault acknowledge.
- `gate_hs`, out, 1: high-side gate.
- `gate_ls`, out, 1: low-side gate.
- `pwm_on`, out, 1: high while in DT_RISE or ON.
- `set_drop`, out, 1: one-cycle pulse when a `set` edge is discarded.
- `max_on_trip`, out, 1: one-cycle pulse on a MAX_ON forced turn-off.
- `fault_lat`, out, 1: high while in FAULT.

## Operation
- Edge detect: `set_pos = set & ~set_dly`. `set_dly` resets to 1, so holding `set` high through reset does not start a cycle.
- States:
  - IDLE: ls=1, hs=0.
  - DT_RISE: both 0.
  - ON: hs=1, ls=0.
  - DT_FALL: both 0.
  - FAULT: both 0.
- Transitions:
  - IDLE → DT_RISE on `set_pos` when `off_cnt ≥ MIN_OFF`. A `set_pos` arriving earlier is discarded and pulses `set_drop`; it is never queued.
  - DT_RISE → ON after `DEAD_TIME` cycles in DT_RISE.
  - ON → DT_FALL when `reset_pwm`=1, or when `on_cnt == MAX_ON-1`. The limit case pulses `max_on_trip`; if both fire in the same cycle, only the trip pulse is issued.
  - DT_FALL → IDLE after `DEAD_TIME` cycles.
  - any state → FAULT when `fault`=1. Fault has highest priority.
  - FAULT → IDLE when `fault`=0 and `clr_fault`=1 in the same cycle.
- Counters:
  - `off_cnt` clears on IDLE entry, increments in IDLE and saturates at `MIN_OFF`.
  - `on_cnt` clears on ON entry and increments in ON.
  - The dead-time counter clears on entry to DT_RISE or DT_FALL.
  - All counters are unsigned `CNT_W` bits and never wrap.
- Ignored inputs:
  - `reset_pwm` outside ON.
  - `set_pos` outside IDLE; this is not counted as a drop.
  - `clr_fault` outside FAULT.
- Invariant: `gate_hs & gate_ls` is never 1, in any cycle, including reset and fault entry.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, `gate_ls`=1, `gate_hs`=0, `pwm_on`=0, `set_drop`=0, `max_on_trip`=0, `fault_lat`=0, `off_cnt`=0.
  - After reset, the full `MIN_OFF` lockout applies.
- Turn-on: `set` rises in cycle N → `gate_ls`=0 and `pwm_on`=1 in N+1 → `gate_hs`=1 in N+1+DEAD_TIME.
- Turn-off: `reset_pwm` is seen in cycle M → `gate_hs`=0 in M+1 → `gate_ls`=1 in M+1+DEAD_TIME.
- Fault seen in cycle F → both gates 0 and `fault_lat`=1 in F+1. No dead time is applied on fault entry.
- Fault exit: release in cycle R → `gate_ls`=1 in R+1, with `off_cnt`=0.
- Minimum period = 2·DEAD_TIME + MIN_OFF + 1 + on-time.
- Reset mid-ON: `gate_hs`=0 and `gate_ls`=1 on the next edge. This is the one sanctioned no-dead-time path, because the driver is disabled during reset.

## Structure
- Shared package `pwm_pkg`:
  - state encoding constants (IDLE=0, DT_RISE=1, ON=2, DT_FALL=3, FAULT=4, 3 bits);
  - default `DEAD_TIME`, `MIN_OFF`, `MAX_ON`, `CNT_W`.
  - The on-time counter stage uses the same package.
- Sub-module: `edge_detect`, a registered rising-edge detector with a reset-value parameter, instantiated for `set`.
- Everything else stays in one FSM plus counters.

## Test plan
Parameters for all scenarios: DEAD_TIME=4, MIN_OFF=10, MAX_ON=50.

- Nominal cycle: reset, wait 12 cycles, `set` rises at cycle 20, `reset_pwm` pulses at cycle 40 → `gate_ls`=0 at 21, `gate_hs`=1 at 25, `gate_hs`=0 at 41, `gate_ls`=1 at 45. Overlap monitor never fires.
- Min-off lockout: after the turn-off above, a `set` edge at cycle 48 (3 cycles into IDLE) → `set_drop` at 49, gates unchanged; a `set` edge at cycle 60 is accepted.
- Max-on: `set` edge, `reset_pwm` never sent → `max_on_trip` pulse and `gate_hs`=0 exactly 50 cycles after `gate_hs` rose.
- Fault during ON: `fault`=1 for 5 cycles mid-ON → both gates 0 on the next edge. Holding `clr_fault`=1 while `fault`=1 keeps FAULT. `fault`=0 plus `clr_fault`=1 → IDLE, `gate_ls`=1.
- Reset with `set` held high: `rst` asserted and released with `set`=1 → no turn-on. `set` low then high after 10 cycles → normal turn-on.
- Simultaneous events: `reset_pwm` and a new `set` edge in the same ON cycle → turn-off proceeds, set ignored, no `set_drop`.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the constant-on-time PWM path: state encoding and
// default timing parameters used by the on-time counter and gate-drive stages.
package pwm_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDtRise = 3'd1,
    StOn     = 3'd2,
    StDtFall = 3'd3,
    StFault  = 3'd4
  } pwm_state_e;

  localparam int unsigned DefDeadTime = 8;
  localparam int unsigned DefMinOff   = 20;
  localparam int unsigned DefMaxOn    = 2000;
  localparam int unsigned DefCntW     = 21;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector; the delay register's reset value decides whether
// an input already high at reset release counts as an edge.
module edge_detect #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= ResetVal;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pwm_gate_drive.sv
// Gate-drive stage: SR-latched PWM state with complementary gates, dead-time insertion,
// minimum off-time lockout, maximum on-time trip and latched fault shutdown.
module pwm_gate_drive
  import pwm_pkg::*;
#(
  parameter int unsigned DEAD_TIME = DefDeadTime,
  parameter int unsigned MIN_OFF   = DefMinOff,
  parameter int unsigned MAX_ON    = DefMaxOn,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic reset_pwm,
  input  logic fault,
  input  logic clr_fault,
  output logic gate_hs,
  output logic gate_ls,
  output logic pwm_on,
  output logic set_drop,
  output logic max_on_trip,
  output logic fault_lat
);

  localparam logic [CNT_W-1:0] DtLast    = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] MinOffCnt = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] MaxOnLast = CNT_W'(MAX_ON - 1);

  pwm_state_e       state_q;
  logic [CNT_W-1:0] off_cnt_q;
  logic [CNT_W-1:0] on_cnt_q;
  logic [CNT_W-1:0] dt_cnt_q;
  logic             set_pos;

  // Reset value 1 so a set held high through reset is not seen as a new request.
  edge_detect #(
    .ResetVal(1'b1)
  ) u_set_edge (
    .clk (clk),
    .rst (rst),
    .d   (set),
    .rise(set_pos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gate_hs     <= 1'b0;
      gate_ls     <= 1'b1;
      pwm_on      <= 1'b0;
      set_drop    <= 1'b0;
      max_on_trip <= 1'b0;
      fault_lat   <= 1'b0;
      off_cnt_q   <= '0;
      on_cnt_q    <= '0;
      dt_cnt_q    <= '0;
    end else begin
      set_drop    <= 1'b0;
      max_on_trip <= 1'b0;
      if (fault) begin
        // Both gates off immediately; no dead time needed when nothing turns on.
        state_q   <= StFault;
        gate_hs   <= 1'b0;
        gate_ls   <= 1'b0;
        pwm_on    <= 1'b0;
        fault_lat <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            if (set_pos && (off_cnt_q >= MinOffCnt)) begin
              state_q  <= StDtRise;
              gate_ls  <= 1'b0;
              pwm_on   <= 1'b1;
              dt_cnt_q <= '0;
            end else begin
              set_drop <= set_pos;
              if (off_cnt_q < MinOffCnt) begin
                off_cnt_q <= off_cnt_q + 1'b1;
              end
            end
          end
          StDtRise: begin
            if (dt_cnt_q == DtLast) begin
              state_q  <= StOn;
              gate_hs  <= 1'b1;
              on_cnt_q <= '0;
            end else begin
              dt_cnt_q <= dt_cnt_q + 1'b1;
            end
          end
          StOn: begin
            // The limit check wins so a coincident reset_pwm still reports the trip.
            if ((on_cnt_q == MaxOnLast) || reset_pwm) begin
              state_q     <= StDtFall;
              gate_hs     <= 1'b0;
              pwm_on      <= 1'b0;
              dt_cnt_q    <= '0;
              max_on_trip <= (on_cnt_q == MaxOnLast);
            end else begin
              on_cnt_q <= on_cnt_q + 1'b1;
            end
          end
          StDtFall: begin
            if (dt_cnt_q == DtLast) begin
              state_q   <= StIdle;
              gate_ls   <= 1'b1;
              off_cnt_q <= '0;
            end else begin
              dt_cnt_q <= dt_cnt_q + 1'b1;
            end
          end
          StFault: begin
            if (clr_fault) begin
              state_q   <= StIdle;
              gate_ls   <= 1'b1;
              fault_lat <= 1'b0;
              off_cnt_q <= '0;
            end
          end
          default: begin
            state_q   <= StIdle;
            gate_hs   <= 1'b0;
            gate_ls   <= 1'b1;
            pwm_on    <= 1'b0;
            fault_lat <= 1'b0;
            off_cnt_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_gate_drive.sv
// Scenario bench for pwm_gate_drive: expected output vectors are queued per cycle as
// stimulus is scheduled and compared when that cycle is reached.
module tb_pwm_gate_drive;

  localparam int unsigned DT    = 4;
  localparam int unsigned MOFF  = 10;
  localparam int unsigned MON   = 50;
  localparam int unsigned CNTW  = 21;

  // {gate_hs, gate_ls, pwm_on, set_drop, max_on_trip, fault_lat}
  localparam logic [5:0] VIdle = 6'b010000;
  localparam logic [5:0] VDrop = 6'b010100;
  localparam logic [5:0] VDtr  = 6'b001000;
  localparam logic [5:0] VOn   = 6'b101000;
  localparam logic [5:0] VDtf  = 6'b000000;
  localparam logic [5:0] VTrip = 6'b000010;
  localparam logic [5:0] VFlt  = 6'b000001;

  typedef struct {
    int         cyc;
    logic [5:0] val;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst, set, reset_pwm, fault, clr_fault;
  logic gate_hs, gate_ls, pwm_on, set_drop, max_on_trip, fault_lat;
  logic [5:0] outs;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   nom_b = 0;
  exp_t sb[$];

  pwm_gate_drive #(
    .DEAD_TIME(DT),
    .MIN_OFF  (MOFF),
    .MAX_ON   (MON),
    .CNT_W    (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set        (set),
    .reset_pwm  (reset_pwm),
    .fault      (fault),
    .clr_fault  (clr_fault),
    .gate_hs    (gate_hs),
    .gate_ls    (gate_ls),
    .pwm_on     (pwm_on),
    .set_drop   (set_drop),
    .max_on_trip(max_on_trip),
    .fault_lat  (fault_lat)
  );

  assign outs = {gate_hs, gate_ls, pwm_on, set_drop, max_on_trip, fault_lat};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    n_chk++;
    if (gate_hs === 1'b1 && gate_ls === 1'b1) begin
      n_err++;
      $display("FAIL overlap cyc=%0d got hs=%b ls=%b want not both 1", cyc, gate_hs, gate_ls);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got no finish want finish", cyc);
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic [5:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic test_nominal();
    int   b = cyc;
    exp_t e;
    nom_b = b;
    expect_at(b + 8,  VIdle, "reset_vals");
    expect_at(b + 21, VDtr,  "nom_ls_low");
    expect_at(b + 24, VDtr,  "nom_dt_rise_end");
    expect_at(b + 25, VOn,   "nom_hs_high");
    expect_at(b + 40, VOn,   "nom_on_hold");
    expect_at(b + 41, VDtf,  "nom_hs_low");
    expect_at(b + 44, VDtf,  "nom_dt_fall_end");
    expect_at(b + 45, VIdle, "nom_ls_high");
    for (int r = 0; r < 45; r++) begin
      rst = (r < 8); set = (r == 20); reset_pwm = (r == 40); fault = 0; clr_fault = 0;
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != cyc || outs !== e.val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc - b, outs, e.val);
        end
      end
    end
  endtask

  task automatic test_min_off();
    int   b = nom_b;
    exp_t e;
    expect_at(b + 49, VDrop, "minoff_drop");
    expect_at(b + 50, VIdle, "minoff_drop_one_cycle");
    expect_at(b + 60, VIdle, "minoff_still_idle");
    expect_at(b + 61, VDtr,  "minoff_accept");
    expect_at(b + 65, VOn,   "minoff_on");
    expect_at(b + 67, VDtf,  "minoff_off");
    expect_at(b + 70, VDtf,  "minoff_dt_fall_end");
    expect_at(b + 71, VIdle, "minoff_idle");
    for (int r = 45; r < 71; r++) begin
      rst = 0; set = (r == 48) || (r == 60); reset_pwm = (r == 66); fault = 0; clr_fault = 0;
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != cyc || outs !== e.val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc - b, outs, e.val);
        end
      end
    end
  endtask

  task automatic test_max_on();
    int   b = cyc;
    exp_t e;
    expect_at(b + 2,  VIdle, "maxon_reset");
    expect_at(b + 16, VDtr,  "maxon_dt_rise");
    expect_at(b + 20, VOn,   "maxon_hs_high");
    expect_at(b + 69, VOn,   "maxon_last_on");
    expect_at(b + 70, VTrip, "maxon_trip");
    expect_at(b + 71, VDtf,  "maxon_trip_one_cycle");
    expect_at(b + 74, VIdle, "maxon_idle");
    for (int r = 0; r < 74; r++) begin
      rst = (r < 2); set = (r == 15); reset_pwm = 0; fault = 0; clr_fault = 0;
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != cyc || outs !== e.val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc - b, outs, e.val);
        end
      end
    end
  endtask

  task automatic test_fault();
    int   b = cyc;
    exp_t e;
    expect_at(b + 20, VOn,   "fault_pre_on");
    expect_at(b + 25, VOn,   "fault_pre_edge");
    expect_at(b + 26, VFlt,  "fault_entry");
    expect_at(b + 29, VFlt,  "fault_hold");
    expect_at(b + 30, VFlt,  "fault_clr_while_active");
    expect_at(b + 31, VIdle, "fault_exit");
    expect_at(b + 32, VIdle, "fault_exit_stays_idle");
    expect_at(b + 36, VDrop, "fault_exit_off_cnt_zero");
    for (int r = 0; r < 36; r++) begin
      rst = (r < 2); set = (r == 15) || (r == 35); reset_pwm = 0;
      fault = (r >= 25 && r <= 29); clr_fault = (r >= 28 && r <= 31);
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != cyc || outs !== e.val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc - b, outs, e.val);
        end
      end
    end
  endtask

  task automatic test_reset_set_high();
    int   b = cyc;
    exp_t e;
    expect_at(b + 3,  VIdle, "rsthi_release");
    expect_at(b + 4,  VIdle, "rsthi_no_start");
    expect_at(b + 12, VIdle, "rsthi_still_idle");
    expect_at(b + 15, VDtr,  "rsthi_turn_on");
    expect_at(b + 19, VOn,   "rsthi_hs_high");
    expect_at(b + 21, VOn,   "rsthi_pre_reset");
    expect_at(b + 22, VIdle, "rsthi_reset_mid_on");
    for (int r = 0; r < 22; r++) begin
      rst = (r < 3) || (r == 21); set = (r != 13); reset_pwm = 0; fault = 0; clr_fault = 0;
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != cyc || outs !== e.val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc - b, outs, e.val);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   b = cyc;
    exp_t e;
    expect_at(b + 20, VOn,   "b2b_on");
    expect_at(b + 25, VOn,   "b2b_pre_events");
    expect_at(b + 26, VDtf,  "b2b_off_no_drop");
    expect_at(b + 27, VDtf,  "b2b_dt_fall");
    expect_at(b + 30, VIdle, "b2b_idle");
    expect_at(b + 31, VIdle, "b2b_idle_no_drop");
    expect_at(b + 42, VDtr,  "b2b_next_cycle");
    for (int r = 0; r < 42; r++) begin
      rst = (r < 2); set = (r == 15) || (r == 25) || (r == 41); reset_pwm = (r == 25);
      fault = 0; clr_fault = 0;
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != cyc || outs !== e.val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc - b, outs, e.val);
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    rst = 1; set = 0; reset_pwm = 0; fault = 0; clr_fault = 0;
    tick();
    test_nominal();
    test_min_off();
    test_max_on();
    test_fault();
    test_reset_set_high();
    test_back_to_back();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_chk++;
      n_err++;
      $display("FAIL %s got=unreached want=%b", e.name, e.val);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
